// File: rtl/chrom_eval_pkg.sv
// Shared definitions for the chromosome evaluation sequencer.
//
// Contents:
//   - Default values for the sequencer parameters (segment count, sequence
//     count, vector width, output count, settle time).
//   - Default index width, derived from the sequence count.
//   - Accumulator word width.
//   - The sequencer state enumeration.
//
// The RST state is always part of the enumeration. The FSM only enters it
// when CHROM_EVAL_PER_SEQ_RESET_EN is defined.
package chrom_eval_pkg;

   localparam int DEF_NUM_SEG = 31;
   localparam int DEF_NUM_SEQ = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_OUT_W   = 8;
   localparam int DEF_SETTLE  = 4;
   localparam int DEF_IDX_W   = $clog2(DEF_NUM_SEQ);
   localparam int SUM_W       = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RST,
      S_APPLY,
      S_SAMPLE,
      S_DONE,
      S_ACK
   } state_e;

endpackage

// File: rtl/chrom_err_accum.sv
// Per-output-bit error accumulators for one fitness evaluation.
//
// Ports:
//   clk      in   sole clock
//   reset    in   async active-high reset, clears every sum
//   clr      in   synchronous clear of every sum (wins over en)
//   en       in   add this cycle's masked mismatches
//   obs      in   OUT_W  observed circuit outputs
//   exp_bits in   OUT_W  expected outputs
//   mask     in   OUT_W  1 = this output bit is compared
//   sum      out  OUT_W*SUM_W  sum j at [SUM_W*j +: SUM_W]
//
// The owner guarantees that the number of enables between clears stays
// below 2**SUM_W. For that reason the sums have no saturation logic.
module chrom_err_accum
   import chrom_eval_pkg::*;
#(
   parameter int OUT_W = DEF_OUT_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clr,
   input  logic                   en,
   input  logic [OUT_W-1:0]       obs,
   input  logic [OUT_W-1:0]       exp_bits,
   input  logic [OUT_W-1:0]       mask,
   output logic [OUT_W*SUM_W-1:0] sum
);

   logic [OUT_W-1:0] miss;
   logic [SUM_W-1:0] sum_q [OUT_W];
   logic [SUM_W-1:0] sum_d [OUT_W];

   assign miss = (obs ^ exp_bits) & mask;

   // Each sum either clears, adds its own mismatch bit, or holds.
   always_comb begin
      for (int j = 0; j < OUT_W; j++) begin
         sum_d[j] = sum_q[j];
         if (clr) begin
            sum_d[j] = '0;
         end else if (en) begin
            sum_d[j] = sum_q[j] + SUM_W'(miss[j]);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int j = 0; j < OUT_W; j++) begin
            sum_q[j] <= '0;
         end
      end else begin
         for (int j = 0; j < OUT_W; j++) begin
            sum_q[j] <= sum_d[j];
         end
      end
   end

   for (genvar g = 0; g < OUT_W; g++) begin : g_sum
      assign sum[SUM_W*g +: SUM_W] = sum_q[g];
   end

endmodule

// File: rtl/chrom_eval_sequencer.sv
// Fabric-side controller that runs one fitness evaluation of a chromosome.
//
// The controller latches the chromosome segments and resets the evolved
// circuit. It then applies each stored input vector for SETTLE cycles and
// samples the circuit outputs one cycle later. Mismatches against the
// expected outputs, limited to the valid mask, are accumulated per output
// bit. The HPS talks to this block through a four-phase handshake:
// start/ready and done/done_feedback.
//
// Ports:
//   clk, reset        clock and async active-high reset
//   start_processing  HPS run request (level)
//   done_feedback     HPS acknowledge of done (level)
//   seq_count         number of sequences requested (clamped to NUM_SEQ)
//   chrom_seg         chromosome words, segment k at [32k +: 32]
//   input_seq         stimulus vectors, vector k at [DATA_W*k +: DATA_W]
//   expected_out      expected outputs, low OUT_W bits of word k
//   valid_out         compare mask, low OUT_W bits of word k
//   circ_out          evolved-circuit outputs
//   ready             idle, accepting start
//   done              results valid
//   chrom_cfg         latched chromosome driven to the circuit
//   circ_in           vector driven to the circuit
//   circ_rst          reset pulse to the circuit
//   error_sum         error count per output bit, bit j at [32j +: 32]
//
// Build option:
//   CHROM_EVAL_PER_SEQ_RESET_EN  When defined, the FSM inserts a one-cycle
//                                RST state (circ_rst=1) before every APPLY.
//                                When undefined, the circuit is reset only
//                                in LOAD, so its state carries across
//                                sequences.
module chrom_eval_sequencer
   import chrom_eval_pkg::*;
#(
   parameter int NUM_SEG = DEF_NUM_SEG,
   parameter int NUM_SEQ = DEF_NUM_SEQ,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int OUT_W   = DEF_OUT_W,
   parameter int SETTLE  = DEF_SETTLE
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start_processing,
   input  logic                   done_feedback,
   input  logic [31:0]            seq_count,
   input  logic [NUM_SEG*32-1:0]  chrom_seg,
   input  logic [NUM_SEQ*DATA_W-1:0] input_seq,
   input  logic [NUM_SEQ*32-1:0]  expected_out,
   input  logic [NUM_SEQ*32-1:0]  valid_out,
   input  logic [OUT_W-1:0]       circ_out,
   output logic                   ready,
   output logic                   done,
   output logic [NUM_SEG*32-1:0]  chrom_cfg,
   output logic [DATA_W-1:0]      circ_in,
   output logic                   circ_rst,
   output logic [OUT_W*SUM_W-1:0] error_sum
);

   localparam int IDX_W = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1;
   // n can equal NUM_SEQ, so it needs one bit more than the index.
   localparam int CNT_W = IDX_W + 1;
   localparam int SET_W = $clog2(SETTLE + 1);

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [CNT_W-1:0]     n_q, n_d;
   logic [SET_W-1:0]     settle_q, settle_d;
   logic [NUM_SEG*32-1:0] chrom_cfg_q, chrom_cfg_d;
   logic [DATA_W-1:0]    circ_in_q, circ_in_d;
   logic [CNT_W-1:0]     n_clamped;
   logic                 acc_clr;
   logic                 acc_en;
   logic                 last_seq;

   assign n_clamped = (seq_count > 32'(NUM_SEQ)) ? CNT_W'(NUM_SEQ) : CNT_W'(seq_count);
   assign last_seq  = ({1'b0, idx_q} == (n_q - 1'b1));

   // Next-state logic and per-state control.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      n_d         = n_q;
      settle_d    = settle_q;
      chrom_cfg_d = chrom_cfg_q;
      acc_clr     = 1'b0;
      acc_en      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_processing) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            chrom_cfg_d = chrom_seg;
            acc_clr     = 1'b1;
            idx_d       = '0;
            n_d         = n_clamped;
            settle_d    = '0;
            if (n_clamped == '0) begin
               state_d = S_DONE;
            end else begin
`ifdef CHROM_EVAL_PER_SEQ_RESET_EN
               state_d = S_RST;
`else
               state_d = S_APPLY;
`endif
            end
         end
`ifdef CHROM_EVAL_PER_SEQ_RESET_EN
         S_RST: begin
            settle_d = '0;
            state_d  = S_APPLY;
         end
`endif
         S_APPLY: begin
            if (settle_q == SET_W'(SETTLE - 1)) begin
               state_d = S_SAMPLE;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         S_SAMPLE: begin
            acc_en = 1'b1;
            if (last_seq) begin
               state_d = S_DONE;
            end else begin
               idx_d    = idx_q + 1'b1;
               settle_d = '0;
`ifdef CHROM_EVAL_PER_SEQ_RESET_EN
               state_d  = S_RST;
`else
               state_d  = S_APPLY;
`endif
            end
         end
         S_DONE: begin
            if (done_feedback) begin
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            if (!start_processing && !done_feedback) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // The vector register is loaded on entry to APPLY. This keeps circ_in
   // correct from the first settle cycle onwards and holds it outside APPLY.
   always_comb begin
      circ_in_d = circ_in_q;
      if ((state_d == S_APPLY) && (state_q != S_APPLY)) begin
         circ_in_d = input_seq[DATA_W*idx_d +: DATA_W];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         n_q         <= '0;
         settle_q    <= '0;
         chrom_cfg_q <= '0;
         circ_in_q   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         n_q         <= n_d;
         settle_q    <= settle_d;
         chrom_cfg_q <= chrom_cfg_d;
         circ_in_q   <= circ_in_d;
      end
   end

   chrom_err_accum #(
      .OUT_W(OUT_W)
   ) u_accum (
      .clk      (clk),
      .reset    (reset),
      .clr      (acc_clr),
      .en       (acc_en),
      .obs      (circ_out),
      .exp_bits (expected_out[32*idx_q +: OUT_W]),
      .mask     (valid_out[32*idx_q +: OUT_W]),
      .sum      (error_sum)
   );

   assign ready     = (state_q == S_IDLE);
   assign done      = (state_q == S_DONE);
   assign circ_rst  = (state_q == S_LOAD) || (state_q == S_RST);
   assign chrom_cfg = chrom_cfg_q;
   assign circ_in   = circ_in_q;

endmodule

// File: tb/tb_chrom_eval_sequencer.sv
// Directed testbench for chrom_eval_sequencer.
//
// The evolved circuit is modelled in one of two ways. In pass-through mode
// it drives circ_in[7:0] straight back on circ_out. Otherwise it drives a
// constant pattern set by the bench. The expected latency and the number of
// circuit reset pulses depend on CHROM_EVAL_PER_SEQ_RESET_EN.
module tb_chrom_eval_sequencer;

   localparam int NUM_SEG = 31;
   localparam int NUM_SEQ = 32;
   localparam int DATA_W  = 32;
   localparam int OUT_W   = 8;
   localparam int SETTLE  = 4;
`ifdef CHROM_EVAL_PER_SEQ_RESET_EN
   localparam int PER_SEQ = SETTLE + 2;
   localparam int RST_PER_SEQ = 1;
`else
   localparam int PER_SEQ = SETTLE + 1;
   localparam int RST_PER_SEQ = 0;
`endif

   logic                      clk = 1'b0;
   logic                      reset = 1'b1;
   logic                      start_processing = 1'b0;
   logic                      done_feedback = 1'b0;
   logic [31:0]               seq_count = '0;
   logic [NUM_SEG*32-1:0]     chrom_seg = '0;
   logic [NUM_SEQ*DATA_W-1:0] input_seq = '0;
   logic [NUM_SEQ*32-1:0]     expected_out = '0;
   logic [NUM_SEQ*32-1:0]     valid_out = '0;
   logic [OUT_W-1:0]          circ_out;
   logic                      ready;
   logic                      done;
   logic [NUM_SEG*32-1:0]     chrom_cfg;
   logic [DATA_W-1:0]         circ_in;
   logic                      circ_rst;
   logic [OUT_W*32-1:0]       error_sum;

   logic                      circ_forced = 1'b0;
   logic [OUT_W-1:0]          forced_out = '0;
   logic [NUM_SEG*32-1:0]     chrom_a;
   logic [NUM_SEG*32-1:0]     chrom_b;
   logic [OUT_W*32-1:0]       exp_sum;

   int checks = 0;
   int errors = 0;

   assign circ_out = circ_forced ? forced_out : circ_in[OUT_W-1:0];

   always #5 clk = ~clk;

   chrom_eval_sequencer #(
      .NUM_SEG(NUM_SEG), .NUM_SEQ(NUM_SEQ), .DATA_W(DATA_W),
      .OUT_W(OUT_W), .SETTLE(SETTLE)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .start_processing (start_processing),
      .done_feedback    (done_feedback),
      .seq_count        (seq_count),
      .chrom_seg        (chrom_seg),
      .input_seq        (input_seq),
      .expected_out     (expected_out),
      .valid_out        (valid_out),
      .circ_out         (circ_out),
      .ready            (ready),
      .done             (done),
      .chrom_cfg        (chrom_cfg),
      .circ_in          (circ_in),
      .circ_rst         (circ_rst),
      .error_sum        (error_sum)
   );

   // Zero every stimulus table.
   task automatic clear_vectors();
      input_seq    = '0;
      expected_out = '0;
      valid_out    = '0;
   endtask

   // Raise start from IDLE and count the edges until done. Start is left high.
   task automatic run_eval(input int budget, output int cycles, output int pulses);
      @(negedge clk);
      start_processing = 1'b1;
      cycles = 0;
      pulses = 0;
      while (cycles < budget) begin
         @(posedge clk);
         #1;
         cycles++;
         if (circ_rst) pulses++;
         if (done) break;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL run_timeout: done=%b after %0d cycles, required 1", done, cycles);
      end
   endtask

   // Complete the handshake and return the FSM to IDLE.
   task automatic ack_release();
      @(negedge clk);
      done_feedback = 1'b1;
      @(negedge clk);
      start_processing = 1'b0;
      @(negedge clk);
      done_feedback = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b, required 1", ready); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b, required 0", done); end
      checks++;
      if (circ_rst !== 1'b0) begin errors++; $display("[TB] FAIL reset_circ_rst: got %b, required 0", circ_rst); end
      checks++;
      if (chrom_cfg !== '0) begin errors++; $display("[TB] FAIL reset_chrom_cfg: got nonzero, required 0"); end
      checks++;
      if (circ_in !== '0) begin errors++; $display("[TB] FAIL reset_circ_in: got %h, required 0", circ_in); end
      checks++;
      if (error_sum !== '0) begin errors++; $display("[TB] FAIL reset_error_sum: got %h, required 0", error_sum); end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_ready: got %b, required 1", ready); end
   endtask

   task automatic test_passthrough();
      int cyc, pul;
      clear_vectors();
      for (int k = 0; k < 3; k++) begin
         input_seq[32*k +: 32]    = 32'hC0DE_0000 + 32'(k * 37 + 5);
         expected_out[32*k +: 32] = 32'(8'(k * 37 + 5));
         valid_out[32*k +: 32]    = 32'h0000_00FF;
      end
      chrom_seg   = chrom_a;
      circ_forced = 1'b0;
      seq_count   = 32'd3;
      run_eval(200, cyc, pul);
      checks++;
      if (cyc != 2 + 3 * PER_SEQ) begin errors++; $display("[TB] FAIL pass_latency: got %0d, required %0d", cyc, 2 + 3 * PER_SEQ); end
      checks++;
      if (pul != 1 + 3 * RST_PER_SEQ) begin errors++; $display("[TB] FAIL pass_rst_pulses: got %0d, required %0d", pul, 1 + 3 * RST_PER_SEQ); end
      checks++;
      if (error_sum !== '0) begin errors++; $display("[TB] FAIL pass_error_sum: got %h, required 0", error_sum); end
      checks++;
      if (chrom_cfg !== chrom_a) begin errors++; $display("[TB] FAIL pass_chrom_cfg: got %h.., required %h..", chrom_cfg[63:0], chrom_a[63:0]); end
      checks++;
      if (circ_in !== 32'hC0DE_004F) begin errors++; $display("[TB] FAIL pass_circ_in_hold: got %h, required C0DE004F", circ_in); end
      ack_release();
      checks++;
      if (ready !== 1'b1) begin errors++; $display("[TB] FAIL pass_back_idle: got %b, required 1", ready); end
   endtask

   task automatic setup_mask_case();
      clear_vectors();
      for (int k = 0; k < 2; k++) begin
         input_seq[32*k +: 32] = 32'h0000_1000 + 32'(k);
         valid_out[32*k +: 32] = 32'h0000_000F;
      end
      circ_forced = 1'b1;
      forced_out  = 8'hFF;
      seq_count   = 32'd2;
   endtask

   task automatic test_mask();
      int cyc, pul;
      setup_mask_case();
      run_eval(200, cyc, pul);
      exp_sum = '0;
      for (int j = 0; j < 4; j++) exp_sum[32*j +: 32] = 32'd2;
      checks++;
      if (error_sum !== exp_sum) begin errors++; $display("[TB] FAIL mask_error_sum: got %h, required %h", error_sum, exp_sum); end
      checks++;
      if (cyc != 2 + 2 * PER_SEQ) begin errors++; $display("[TB] FAIL mask_latency: got %0d, required %0d", cyc, 2 + 2 * PER_SEQ); end
      ack_release();
   endtask

   task automatic test_mixed();
      int cyc, pul;
      clear_vectors();
      input_seq[31:0]  = 32'h11; expected_out[31:0]  = 32'h11; valid_out[31:0]  = 32'hFF;
      input_seq[63:32] = 32'h22; expected_out[63:32] = 32'h21; valid_out[63:32] = 32'hFF;
      input_seq[95:64] = 32'h33; expected_out[95:64] = 32'h33; valid_out[95:64] = 32'hFF;
      input_seq[127:96] = 32'h44; expected_out[127:96] = 32'hC5; valid_out[127:96] = 32'h80;
      circ_forced = 1'b0;
      seq_count   = 32'd4;
      run_eval(200, cyc, pul);
      exp_sum = '0;
      exp_sum[31:0]    = 32'd1;
      exp_sum[63:32]   = 32'd1;
      exp_sum[255:224] = 32'd1;
      checks++;
      if (error_sum !== exp_sum) begin errors++; $display("[TB] FAIL mixed_error_sum: got %h, required %h", error_sum, exp_sum); end
      ack_release();
   endtask

   task automatic test_zero_count();
      int cyc, pul;
      seq_count = 32'd0;
      run_eval(50, cyc, pul);
      checks++;
      if (cyc != 2) begin errors++; $display("[TB] FAIL zero_latency: got %0d, required 2", cyc); end
      checks++;
      if (error_sum !== '0) begin errors++; $display("[TB] FAIL zero_error_sum: got %h, required 0", error_sum); end
      checks++;
      if (pul != 1) begin errors++; $display("[TB] FAIL zero_rst_pulses: got %0d, required 1", pul); end
      ack_release();
   endtask

   task automatic test_count_clamp();
      int cyc, pul;
      clear_vectors();
      for (int k = 0; k < NUM_SEQ; k++) begin
         input_seq[32*k +: 32]    = 32'(k * 3 + 1);
         expected_out[32*k +: 32] = 32'(8'(k * 3 + 1) ^ 8'h01);
         valid_out[32*k +: 32]    = 32'h0000_00FF;
      end
      circ_forced = 1'b0;
      seq_count   = 32'd100;
      run_eval(1000, cyc, pul);
      exp_sum = '0;
      exp_sum[31:0] = 32'd32;
      checks++;
      if (cyc != 2 + 32 * PER_SEQ) begin errors++; $display("[TB] FAIL clamp_latency: got %0d, required %0d", cyc, 2 + 32 * PER_SEQ); end
      checks++;
      if (error_sum !== exp_sum) begin errors++; $display("[TB] FAIL clamp_error_sum: got %h, required %h", error_sum, exp_sum); end
      ack_release();
   endtask

   task automatic test_start_held();
      int cyc, pul;
      clear_vectors();
      input_seq[31:0] = 32'h5A; expected_out[31:0] = 32'h5A; valid_out[31:0] = 32'hFF;
      seq_count = 32'd1;
      run_eval(100, cyc, pul);
      @(negedge clk);
      done_feedback = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || ready !== 1'b0) begin errors++; $display("[TB] FAIL held_ack: got done=%b ready=%b, required 0 0", done, ready); end
      @(negedge clk);
      done_feedback = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b0 || circ_rst !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL held_no_retrigger: got ready=%b circ_rst=%b done=%b, required 0 0 0", ready, circ_rst, done);
      end
      @(negedge clk);
      start_processing = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b1) begin errors++; $display("[TB] FAIL held_release: got %b, required 1", ready); end
   endtask

   task automatic test_chrom_snapshot();
      int cyc, pul;
      chrom_seg = chrom_a;
      seq_count = 32'd2;
      @(negedge clk);
      start_processing = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chrom_seg = chrom_b;
      cyc = 0;
      while (cyc < 200 && done !== 1'b1) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checks++;
      if (chrom_cfg !== chrom_a) begin errors++; $display("[TB] FAIL snap_hold: got %h.., required %h..", chrom_cfg[63:0], chrom_a[63:0]); end
      ack_release();
      run_eval(200, cyc, pul);
      checks++;
      if (chrom_cfg !== chrom_b) begin errors++; $display("[TB] FAIL snap_reload: got %h.., required %h..", chrom_cfg[63:0], chrom_b[63:0]); end
      ack_release();
   endtask

   task automatic test_reset_mid_run();
      int cyc, pul;
      setup_mask_case();
      @(negedge clk);
      start_processing = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      exp_sum = '0;
      for (int j = 0; j < 4; j++) exp_sum[32*j +: 32] = 32'd1;
      checks++;
      if (error_sum !== exp_sum) begin errors++; $display("[TB] FAIL midrun_partial: got %h, required %h", error_sum, exp_sum); end
      #1;
      reset = 1'b1;
      start_processing = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b1 || done !== 1'b0 || circ_rst !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrun_ctrl: got ready=%b done=%b circ_rst=%b, required 1 0 0", ready, done, circ_rst);
      end
      checks++;
      if (error_sum !== '0 || circ_in !== '0 || chrom_cfg !== '0) begin
         errors++;
         $display("[TB] FAIL midrun_clear: got sum=%h circ_in=%h, required 0 0", error_sum, circ_in);
      end
      @(negedge clk);
      reset = 1'b0;
      run_eval(200, cyc, pul);
      exp_sum = '0;
      for (int j = 0; j < 4; j++) exp_sum[32*j +: 32] = 32'd2;
      checks++;
      if (error_sum !== exp_sum) begin errors++; $display("[TB] FAIL midrun_rerun: got %h, required %h", error_sum, exp_sum); end
      ack_release();
   endtask

   // Run every scenario in sequence, then print the summary.
   initial begin
      for (int k = 0; k < NUM_SEG; k++) begin
         chrom_a[32*k +: 32] = 32'hA000_0000 + 32'(k);
         chrom_b[32*k +: 32] = 32'hB000_0000 ^ 32'(k * 7);
      end
      test_reset();
      test_passthrough();
      test_mask();
      test_mixed();
      test_zero_count();
      test_count_clamp();
      test_start_held();
      test_chrom_snapshot();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
